kogge: RTL and testbench

KOGGE -- requirements
Module: kogge

---
 rtl/kogge_pkg.sv | 18 +
 rtl/ks_prefix_cell.sv | 14 +
 rtl/kogge.sv | 75 +++++++
 tb/tb_kogge.sv | 131 +++++++++++++
 4 files changed

// File: rtl/kogge_pkg.sv
// rtl/kogge_pkg.sv - shared width constant and prefix-depth helper for the Kogge-Stone adder
package kogge_pkg;

    localparam int KS_N = 4;

    // Prefix depth covering N bit positions plus the carry-in slot: ceil(log2(n+1)).
    function automatic int ks_levels(input int n);
        int lv;
        lv = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << lv) < (n + 1)) begin
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// rtl/ks_prefix_cell.sv - (G,P) prefix operator; used as a gray cell when P is left open
module ks_prefix_cell (
    input  logic Gh,
    input  logic Ph,
    input  logic Gl,
    input  logic Pl,
    output logic G,
    output logic P
);

    assign G = Gh | (Ph & Gl);
    assign P = Ph & Pl;

endmodule

// File: rtl/kogge.sv
// rtl/kogge.sv - registered N-bit Kogge-Stone adder, Sum = A + B + Cin with carry-out in bit N
module kogge
    import kogge_pkg::*;
#(
    parameter int N = KS_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N:0]   Sum
);

    localparam int L = ks_levels(N);

    // Slot 0 of every level is the carry-in at bit position -1; slot j holds bit j-1.
    logic [L:0][N:0] gk;
    logic [L:0][N:0] pk;
    logic [N-1:0]    g;
    logic [N-1:0]    p;
    logic [N:0]      c;
    logic [N:0]      sum_d;
    logic [N:0]      sum_q;

    assign g = A & B;
    assign p = A ^ B;

    assign gk[0] = {g, Cin};
    assign pk[0] = {p, 1'b0};

    for (genvar k = 0; k < L; k++) begin : g_level
        localparam int S = 1 << k;
        for (genvar j = 0; j <= N; j++) begin : g_node
            if (j < S) begin : g_pass
                assign gk[k+1][j] = gk[k][j];
                assign pk[k+1][j] = pk[k][j];
            end else if (j - S < S) begin : g_gray
                // Low span already reaches the carry-in, so G is a final carry.
                ks_prefix_cell u_cell (
                    .Gh (gk[k][j]),
                    .Ph (pk[k][j]),
                    .Gl (gk[k][j-S]),
                    .Pl (pk[k][j-S]),
                    .G  (gk[k+1][j]),
                    .P  ()
                );
                assign pk[k+1][j] = 1'b0;
            end else begin : g_black
                ks_prefix_cell u_cell (
                    .Gh (gk[k][j]),
                    .Ph (pk[k][j]),
                    .Gl (gk[k][j-S]),
                    .Pl (pk[k][j-S]),
                    .G  (gk[k+1][j]),
                    .P  (pk[k+1][j])
                );
            end
        end
    end

    assign c     = gk[L];
    assign sum_d = {c[N], p ^ c[N-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign Sum = sum_q;

endmodule

// File: tb/tb_kogge.sv
// tb/tb_kogge.sv - directed and random checks of kogge at widths 4, 8 and 5
module tb_kogge;

    logic       clk;
    logic       rst;
    logic [3:0] a4, b4;
    logic       c4;
    logic [4:0] s4;
    logic [7:0] a8, b8;
    logic       c8;
    logic [8:0] s8;
    logic [4:0] a5, b5;
    logic       c5;
    logic [5:0] s5;

    int checks;
    int errors;

    kogge #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .Sum(s4));
    kogge #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .Sum(s8));
    kogge #(.N(5)) u_dut5 (.clk(clk), .rst(rst), .A(a5), .B(b5), .Cin(c5), .Sum(s5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string name, input logic [4:0] exp);
        checks++;
        if (s4 !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, s4, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk4("reset", 5'h00);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 512; v++) begin
            {c4, b4, a4} = v[8:0];
            step();
            chk4("sweep", 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]));
        end
    endtask

    task automatic test_corners();
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; step(); chk4("all_ones", 5'h1F);
        a4 = 4'hF; b4 = 4'h0; c4 = 1'b1; step(); chk4("carry_chain", 5'h10);
        a4 = 4'h5; b4 = 4'hA; c4 = 1'b0; step(); chk4("alt_bits", 5'h0F);
        a4 = 4'h0; b4 = 4'h0; c4 = 1'b0; step(); chk4("zeros", 5'h00);
    endtask

    task automatic test_hold();
        a4 = 4'h7; b4 = 4'h6; c4 = 1'b1; step();
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        #3;
        chk4("hold", 5'h0E);
        step();
        chk4("after_hold", 5'h1F);
    endtask

    task automatic test_back_to_back();
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; step(); chk4("b2b_first", 5'h10);
        rst = 1'b1; a4 = 4'h3; b4 = 4'h4; c4 = 1'b1; step(); chk4("b2b_reset", 5'h00);
        rst = 1'b0; step(); chk4("b2b_after", 5'h08);
    endtask

    task automatic test_wide();
        logic [8:0] e8;
        logic [5:0] e5;
        for (int i = 0; i < 10000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            a5 = 5'($urandom); b5 = 5'($urandom); c5 = 1'($urandom);
            e8 = 9'(a8) + 9'(b8) + 9'(c8);
            e5 = 6'(a5) + 6'(b5) + 6'(c5);
            step();
            checks++;
            if (s8 !== e8) begin
                errors++;
                $display("FAIL rand8: got %h expected %h", s8, e8);
            end
            checks++;
            if (s5 !== e5) begin
                errors++;
                $display("FAIL rand5: got %h expected %h", s5, e5);
            end
        end
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        a5 = 5'h1F; b5 = 5'h1F; c5 = 1'b1;
        step();
        checks++;
        if (s8 !== 9'h1FF) begin
            errors++;
            $display("FAIL ones8: got %h expected 1ff", s8);
        end
        checks++;
        if (s5 !== 6'h3F) begin
            errors++;
            $display("FAIL ones5: got %h expected 3f", s5);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a4 = '0; b4 = '0; c4 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;
        a5 = '0; b5 = '0; c5 = 1'b0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_corners();
        test_hold();
        test_back_to_back();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
